// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the iterative 32x32 multiplier sequencer:
// FSM state encodings, step count and counter width.
package mult32_seq_pkg;

   localparam int unsigned MULT_STEPS = 32;
   localparam int unsigned CNT_W      = 5;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_RUN  = 2'd1,
      MS_FIX  = 2'd2,
      MS_FIN  = 2'd3
   } ms_state_e;

endpackage

// File: rtl/mult32_seq_dp.sv
// Datapath of the iterative multiplier: operand magnitude capture, shared
// (WIDTH+1)-bit adder, 2*WIDTH shift accumulator, final sign fix, HI/LO regs.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   load_i     capture operands/sign, clear accumulator high half
//   step_i     one add-and-shift step
//   fix_i      apply sign and load HI/LO
//   signed_i   operands are two's complement
//   a_i, b_i   multiplicand / multiplier
//   hi_o, lo_o registered product halves
import mult32_seq_pkg::*;

module mult32_seq_dp #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             fix_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [WIDTH-1:0] mcand_q;
   logic [PW-1:0]    acc_q;     // {acc_hi, mplier}
   logic             neg_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             a_neg_c, b_neg_c, neg_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c, addend_c;
   logic [WIDTH:0]   sum_c;
   logic [PW-1:0]    prod_c;

   // Operand magnitudes; the most negative value maps to itself, which is
   // the correct unsigned magnitude.
   always_comb begin
      a_neg_c = signed_i & a_i[WIDTH-1];
      b_neg_c = signed_i & b_i[WIDTH-1];
      neg_c   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      a_mag_c = a_neg_c ? (~a_i + WIDTH'(1)) : a_i;
      b_mag_c = b_neg_c ? (~b_i + WIDTH'(1)) : b_i;
   end

   // Shared adder; carry is kept and shifted into the accumulator MSB.
   always_comb begin
      addend_c = acc_q[0] ? mcand_q : WIDTH'(0);
      sum_c    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend_c};
      prod_c   = neg_q ? (~acc_q + PW'(1)) : acc_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mcand_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         if (load_i) begin
            mcand_q <= a_mag_c;
            acc_q   <= {WIDTH'(0), b_mag_c};
            neg_q   <= neg_c;
         end
         if (step_i) begin
            acc_q <= {sum_c, acc_q[WIDTH-1:1]};
         end
         if (fix_i) begin
            hi_q <= prod_c[PW-1:WIDTH];
            lo_q <= prod_c[WIDTH-1:0];
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/mult32_seq.sv
// Iterative multiplier sequencer: FSM, step counter and BUSY/DONE flags.
// One multiplier bit per clock; result in HI/LO 33 edges after START.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   START     request, honoured only in IDLE
//   SIGNED    two's-complement operands when 1
//   A, B      multiplicand / multiplier
//   HI, LO    registered product [63:32] / [31:0]
//   BUSY      high in RUN and FIX
//   DONE      one-cycle completion pulse
import mult32_seq_pkg::*;

module mult32_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_STEPS - 1);

   ms_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_c, step_c, fix_c;

   // Next-state, counter and datapath enables.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_c  = 1'b0;
      step_c  = 1'b0;
      fix_c   = 1'b0;
      unique case (state_q)
         MS_IDLE: begin
            if (START) begin
               load_c  = 1'b1;
               cnt_d   = '0;
               state_d = MS_RUN;
            end
         end
         MS_RUN: begin
            step_c = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = MS_FIX;
            end
         end
         MS_FIX: begin
            fix_c   = 1'b1;
            state_d = MS_FIN;
         end
         MS_FIN: begin
            state_d = MS_IDLE;
         end
         default: begin
            state_d = MS_IDLE;
         end
      endcase
      busy_d = (state_d == MS_RUN) || (state_d == MS_FIX);
      done_d = (state_d == MS_FIN);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= MS_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   mult32_seq_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .CLK      (CLK),
      .RST      (RST),
      .load_i   (load_c),
      .step_i   (step_c),
      .fix_i    (fix_c),
      .signed_i (SIGNED),
      .a_i      (A),
      .b_i      (B),
      .hi_o     (HI),
      .lo_o     (LO)
   );

   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: products, latency, START-while-busy and reset.
module tb_mult32_seq;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        SIGNED;
   logic [31:0] A, B;
   logic [31:0] HI, LO;
   logic        BUSY, DONE;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   mult32_seq #(.WIDTH(32)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .SIGNED (SIGNED),
      .A      (A),
      .B      (B),
      .HI     (HI),
      .LO     (LO),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // START sampled at the next rising edge (E0); returns #1 after E0.
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      SIGNED = s; A = a; B = b; START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   // Edges counted until DONE is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (DONE !== 1'b1 && lat < 100) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1) cnt++;
      end
   endtask

   task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
      int lat;
      start_op(s, a, b);
      check({tag, "_busy"}, 64'(BUSY), 64'(1));
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'(33));
      check({tag, "_prod"}, {HI, LO}, exp);
      check({tag, "_busy_fin"}, 64'(BUSY), 64'(0));
      @(posedge CLK);
      #1;
      check({tag, "_done_off"}, 64'(DONE), 64'(0));
      check({tag, "_hold"}, {HI, LO}, exp);
   endtask

   initial begin
      int lat;
      int cnt;
      RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_hi", 64'(HI), 64'(0));
      check("rst_lo", 64'(LO), 64'(0));
      check("rst_busy", 64'(BUSY), 64'(0));
      check("rst_done", 64'(DONE), 64'(0));
      @(negedge CLK);
      RST = 1'b0;

      // Back-to-back: each following START lands at E0+35.
      do_op("u3x5",   1'b0, 32'd3,          32'd5,          64'h00000000_0000000F);
      do_op("uffxff", 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001);
      do_op("sm7x3",  1'b1, 32'hFFFFFFF9,   32'd3,          64'hFFFFFFFF_FFFFFFEB);
      do_op("sm1xm1", 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001);
      do_op("s80x80", 1'b1, 32'h80000000,   32'h80000000,   64'h40000000_00000000);
      do_op("s123",   1'b1, 32'd123,        32'hFFFFFE38,   64'hFFFFFFFF_FFFF24E8);
      do_op("s0xm5",  1'b1, 32'd0,          32'hFFFFFFFB,   64'h0);
      do_op("u0xm5",  1'b0, 32'd0,          32'hFFFFFFFB,   64'h0);

      // START with new operands at E0+10 while busy is dropped.
      start_op(1'b0, 32'd6, 32'd7);
      repeat (9) @(posedge CLK);
      #1;
      check("ign_hold_run", {HI, LO}, 64'h0);
      @(negedge CLK);
      A = 32'd5; B = 32'd5; START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      wait_done(lat);
      check("ign_lat", 64'(lat), 64'(23));
      check("ign_prod", {HI, LO}, 64'd42);
      count_done(40, cnt);
      check("ign_no_2nd_done", 64'(cnt), 64'(0));
      check("ign_hold_idle", {HI, LO}, 64'd42);

      // Reset mid-run at E0+15.
      start_op(1'b0, 32'd9, 32'd9);
      repeat (14) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("rrun_busy", 64'(BUSY), 64'(0));
      check("rrun_done", 64'(DONE), 64'(0));
      check("rrun_prod", {HI, LO}, 64'h0);
      @(negedge CLK);
      RST = 1'b0;
      count_done(40, cnt);
      check("rrun_no_done", 64'(cnt), 64'(0));
      do_op("after_rst", 1'b0, 32'd11, 32'd13, 64'd143);

      // RST and START together: reset wins.
      @(negedge CLK);
      RST = 1'b1; START = 1'b1; A = 32'd2; B = 32'd2;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      @(posedge CLK);
      #1;
      check("rst_start_busy", 64'(BUSY), 64'(0));
      check("rst_start_prod", {HI, LO}, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Iterative 32x32 multiplier sequencer. It accepts two operands on a START pulse and computes the full 64-bit product with one shared 32-bit adder and a shift register, one multiplier bit per clock. It handles both signed and unsigned operands and reports completion with a one-cycle DONE pulse. It sits beside the ALU as the low-area multiply path and is driven by the control unit for MUL/MULT instructions.

## Interface
Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH. Only 32 is verified.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  request; sampled only in IDLE.
- SIGNED  in  1  1 = two's-complement operands, 0 = unsigned; captured with START.
- A  in  32  multiplicand; captured with START.
- B  in  32  multiplier; captured with START.
- HI  out  32  product bits [63:32]; registered.
- LO  out  32  product bits [31:0]; registered.
- BUSY  out  1  high in RUN and FIX.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, FIX, FIN.
- IDLE with START=1:
  - Captures |A| and |B|. Magnitudes are used only when SIGNED=1 and the operand's bit 31 is set.
  - Captures neg = SIGNED & (A[31]^B[31]).
  - Clears the accumulator and the bit counter.
  - Moves to RUN.
- RUN, one step per edge:
  - If the multiplier LSB is 1, acc_hi = acc_hi + mcand, using a 33-bit sum (carry kept).
  - Then {carry, acc_hi, mplier} shifts right by 1.
  - Counter increments.
  - After the 32nd step (counter wraps 31→0), moves to FIX.
- FIX:
  - If neg=1, the 64-bit product becomes its two's complement; otherwise it is unchanged.
  - Loads the result into HI/LO and moves to FIN.
- FIN: DONE=1 for this one cycle, then IDLE unconditionally.
- Boundary rules:
  - START in RUN, FIX or FIN is ignored and is not queued. Operand changes after capture are ignored.
  - |0x80000000| = 0x80000000 is correct as an unsigned 32-bit magnitude; no special case.
  - Negating a zero product yields zero.
  - HI/LO hold the last result until the next FIX. They do not change in IDLE, RUN or FIN.
  - RST=1 in any state: next state IDLE; HI, LO, acc, counter and neg are cleared; BUSY=0, DONE=0. Any in-flight operation is discarded.
  - RST and START together: RST wins.

## Timing
- Reset values: HI=0, LO=0, BUSY=0, DONE=0, state IDLE.
- START sampled at edge E0. BUSY is high from E0+1 through the cycle that ends at edge E0+33.
- HI/LO update at edge E0+33.
- DONE is high during the cycle after E0+33 and is low again after E0+34.
- Back-to-back operation: the earliest next accepted START is at edge E0+35 (IDLE). Issue rate is 1 operation per 35 cycles.
- Result is valid whenever DONE=1 and stays valid until the next FIX.
- No combinational path from inputs to outputs.

## Structure
- Shared header prj_definition.v holds:
  - state encodings: MS_IDLE=2'd0, MS_RUN=2'd1, MS_FIX=2'd2, MS_FIN=2'd3.
  - MULT_STEPS=32 and a 5-bit counter width constant.
- Split into two modules:
  - mult32_seq: FSM, counter, BUSY/DONE.
  - mult32_seq_dp: datapath (magnitude/negate logic, 33-bit adder, 64-bit shift accumulator, HI/LO registers), driven by load/step/fix enables.
- The adder and negators may instantiate the existing RC_ADD_SUB_32 / TWOSCOMP32 / TWOSCOMP64 cells.

## Test plan
- Unsigned 3 × 5, START at E0 → HI=0x00000000, LO=0x0000000F. DONE is high exactly in the cycle after E0+33; BUSY=0 afterwards.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed cases:
  - (-7) × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - (-1) × (-1) → HI=0, LO=1.
  - 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Signed 0 × (-5) → HI=0, LO=0. Same A/B with SIGNED=0 → HI=0, LO=0.
- START pulsed with new operands at E0+10 while BUSY → ignored; the first result is unchanged and no second DONE occurs. A START at E0+35 is accepted.
- RST asserted at E0+15 → next cycle BUSY=0, HI=LO=0, no DONE. A new START after release gives the correct product at standard latency.
